// File: rtl/craft_sub_cells_serial.sv
// craft_sub_cells_serial: serialized SubCells layer of the CRAFT round datapath.
// A 64-bit state is accepted in IDLE and then substituted NIBBLES_PER_CYCLE
// nibbles per clock, starting at nibble 0 (bits [63:60]). The result is held in
// DONE until the downstream stage takes it.
//
// Ports:
//   CLK        rising-edge clock
//   RST        asynchronous, active-high reset
//   in_valid   upstream presents in_state
//   in_ready   block can accept a state (IDLE only, low while RST is high)
//   in_state   64-bit cipher state, nibble 0 = bits [63:60]
//   out_valid  out_state holds the fully substituted state
//   out_ready  downstream accepts out_state
//   out_state  substituted state, straight from the state register
//   busy       high in SUB or DONE
//
// craft_sbox: 4-bit CRAFT S-box (an involution).
//   din   nibble in
//   dout  substituted nibble

module craft_sbox (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        case (din)
            4'h0: dout = 4'hc;
            4'h1: dout = 4'ha;
            4'h2: dout = 4'hd;
            4'h3: dout = 4'h3;
            4'h4: dout = 4'he;
            4'h5: dout = 4'hb;
            4'h6: dout = 4'hf;
            4'h7: dout = 4'h7;
            4'h8: dout = 4'h8;
            4'h9: dout = 4'h9;
            4'ha: dout = 4'h1;
            4'hb: dout = 4'h5;
            4'hc: dout = 4'h0;
            4'hd: dout = 4'h2;
            4'he: dout = 4'h4;
            default: dout = 4'h6;
        endcase
    end

endmodule

module craft_sub_cells_serial #(
    parameter int unsigned NIBBLES_PER_CYCLE = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_state,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_state,
    output logic        busy
);

    localparam int unsigned STEPS = 16 / NIBBLES_PER_CYCLE;
    // Counter is kept at least one bit wide so the N=16 build still elaborates.
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    generate
        if (!(NIBBLES_PER_CYCLE == 1 || NIBBLES_PER_CYCLE == 2 ||
              NIBBLES_PER_CYCLE == 4 || NIBBLES_PER_CYCLE == 8 ||
              NIBBLES_PER_CYCLE == 16)) begin : g_bad_param
            $error("craft_sub_cells_serial: NIBBLES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } fsm_t;

    fsm_t          fsm;
    logic [CW-1:0] cnt;
    logic [63:0]   state_q;
    logic [63:0]   state_next;
    logic          out_valid_q;
    logic          busy_q;

    logic [3:0] sb_in  [NIBBLES_PER_CYCLE];
    logic [3:0] sb_out [NIBBLES_PER_CYCLE];

    // Route the current nibble group through the S-box instances and merge the
    // results back; every other nibble passes through untouched.
    always_comb begin
        int unsigned base;
        base       = 32'(cnt) * NIBBLES_PER_CYCLE;
        state_next = state_q;
        for (int unsigned i = 0; i < NIBBLES_PER_CYCLE; i++) begin
            sb_in[i] = state_q[63 - 4 * (base + i) -: 4];
            state_next[63 - 4 * (base + i) -: 4] = sb_out[i];
        end
    end

    for (genvar g = 0; g < NIBBLES_PER_CYCLE; g++) begin : g_sbox
        craft_sbox u_sbox (
            .din  (sb_in[g]),
            .dout (sb_out[g])
        );
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fsm         <= IDLE;
            cnt         <= '0;
            state_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= in_state;
                        cnt     <= '0;
                        busy_q  <= 1'b1;
                        fsm     <= SUB;
                    end
                end
                SUB: begin
                    state_q <= state_next;
                    if (cnt == CW'(STEPS - 1)) begin
                        cnt         <= '0;
                        out_valid_q <= 1'b1;
                        fsm         <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        fsm         <= IDLE;
                    end
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

    // Gated by RST so upstream never sees ready while reset is held.
    assign in_ready  = (fsm == IDLE) && !RST;
    assign out_valid = out_valid_q;
    assign out_state = state_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_craft_sub_cells_serial.sv
// tb_craft_sub_cells_serial: directed self-checking bench for
// craft_sub_cells_serial. A main N=1 instance carries the handshake tests; N=4
// and N=16 instances share its inputs for the latency/equivalence check.

module tb_craft_sub_cells_serial;

    localparam int unsigned STEPS = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic [63:0] in_state;
    logic        out_ready;

    logic        in_ready1, out_valid1, busy1;
    logic [63:0] out_state1;
    logic        in_ready4, out_valid4, busy4;
    logic [63:0] out_state4;
    logic        in_ready16, out_valid16, busy16;
    logic [63:0] out_state16;

    int nvec  = 0;
    int nfail = 0;
    int cyc   = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    craft_sub_cells_serial #(.NIBBLES_PER_CYCLE(1)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready1),
        .in_state(in_state), .out_valid(out_valid1), .out_ready(out_ready),
        .out_state(out_state1), .busy(busy1)
    );

    craft_sub_cells_serial #(.NIBBLES_PER_CYCLE(4)) dut4 (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready4),
        .in_state(in_state), .out_valid(out_valid4), .out_ready(out_ready),
        .out_state(out_state4), .busy(busy4)
    );

    craft_sub_cells_serial #(.NIBBLES_PER_CYCLE(16)) dut16 (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready16),
        .in_state(in_state), .out_valid(out_valid16), .out_ready(out_ready),
        .out_state(out_state16), .busy(busy16)
    );

    function automatic logic [3:0] ref_sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'hc;  4'h1: return 4'ha;  4'h2: return 4'hd;  4'h3: return 4'h3;
            4'h4: return 4'he;  4'h5: return 4'hb;  4'h6: return 4'hf;  4'h7: return 4'h7;
            4'h8: return 4'h8;  4'h9: return 4'h9;  4'ha: return 4'h1;  4'hb: return 4'h5;
            4'hc: return 4'h0;  4'hd: return 4'h2;  4'he: return 4'h4;  default: return 4'h6;
        endcase
    endfunction

    function automatic logic [63:0] ref_sub64(input logic [63:0] s);
        logic [63:0] r;
        for (int k = 0; k < 16; k++) r[4*k +: 4] = ref_sbox(s[4*k +: 4]);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wait (bounded) for in_ready on the main instance, at a negedge.
    task automatic wait_ready(input string name);
        int t;
        t = 0;
        while (!in_ready1 && t < 60) begin
            @(negedge CLK);
            t++;
        end
        check(name, 64'(in_ready1), 64'd1);
    endtask

    // Counts edges after acceptance until out_valid is seen; returns the count.
    task automatic wait_out(output int n);
        bit seen;
        seen = 0;
        n = 0;
        while (!seen && n < 60) begin
            @(posedge CLK);
            n++;
            @(negedge CLK);
            if (out_valid1) seen = 1;
        end
    endtask

    // One complete transaction with out_ready held high.
    task automatic run_one(input string name, input logic [63:0] din, input logic [63:0] exp);
        int n;
        @(negedge CLK);
        wait_ready({name, "_ready"});
        in_valid = 1'b1;
        in_state = din;
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
        in_state = {$urandom, $urandom};   // must have no effect after acceptance
        check({name, "_busy"}, 64'(busy1), 64'd1);
        wait_out(n);
        check({name, "_latency"}, 64'(n), 64'(STEPS));
        check({name, "_data"}, out_state1, exp);
        @(posedge CLK);
        @(negedge CLK);
        check({name, "_idle_ov"}, 64'(out_valid1), 64'd0);
        check({name, "_idle_rdy"}, 64'(in_ready1), 64'd1);
    endtask

    typedef struct {
        logic [63:0] din;
        logic [63:0] exp;
    } vec_t;

    vec_t        tbl[6];
    logic [63:0] bs[4];
    int          outcyc[4];
    int          n, lat1, lat4, lat16;
    logic [63:0] res1, res4, res16, held;

    initial begin
        tbl[0] = '{64'h0123456789ABCDEF, 64'hCAD3EBF789150246};
        tbl[1] = '{64'h0000000000000000, 64'hCCCCCCCCCCCCCCCC};
        tbl[2] = '{64'hCAD3EBF789150246, 64'h0123456789ABCDEF};
        tbl[3] = '{64'hFFFFFFFFFFFFFFFF, 64'h6666666666666666};
        tbl[4] = '{64'hFEDCBA9876543210, 64'h642051987FBE3DAC};
        tbl[5] = '{64'h1111111111111111, 64'hAAAAAAAAAAAAAAAA};

        RST       = 1'b1;
        in_valid  = 1'b0;
        in_state  = 64'h0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_in_ready", 64'(in_ready1), 64'd0);
        check("rst_out_valid", 64'(out_valid1), 64'd0);
        check("rst_busy", 64'(busy1), 64'd0);
        check("rst_out_state", out_state1, 64'h0);
        RST = 1'b0;
        @(negedge CLK);
        check("rel_in_ready", 64'(in_ready1), 64'd1);

        // N=1/4/16 builds on the same vector
        check("mb_rdy4", 64'(in_ready4), 64'd1);
        check("mb_rdy16", 64'(in_ready16), 64'd1);
        in_valid = 1'b1;
        in_state = 64'h0123456789ABCDEF;
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
        lat1 = 0; lat4 = 0; lat16 = 0;
        res1 = '0; res4 = '0; res16 = '0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (out_valid1 && lat1 == 0) begin lat1 = i; res1 = out_state1; end
            if (out_valid4 && lat4 == 0) begin lat4 = i; res4 = out_state4; end
            if (out_valid16 && lat16 == 0) begin lat16 = i; res16 = out_state16; end
        end
        check("mb_lat1", 64'(lat1), 64'd16);
        check("mb_lat4", 64'(lat4), 64'd4);
        check("mb_lat16", 64'(lat16), 64'd1);
        check("mb_res1", res1, 64'hCAD3EBF789150246);
        check("mb_res4", res4, 64'hCAD3EBF789150246);
        check("mb_res16", res16, 64'hCAD3EBF789150246);

        // Table-driven single transactions
        for (int i = 0; i < 6; i++) begin
            run_one($sformatf("vec%0d", i), tbl[i].din, tbl[i].exp);
        end

        // Back-to-back with in_valid and out_ready held high
        for (int k = 0; k < 4; k++) bs[k] = {$urandom, $urandom};
        @(negedge CLK);
        in_valid = 1'b1;
        in_state = bs[0];
        for (int k = 0; k < 4; k++) begin
            wait_ready($sformatf("b2b%0d_ready", k));
            @(posedge CLK);
            @(negedge CLK);
            if (k < 3) in_state = bs[k + 1];
            wait_out(n);
            outcyc[k] = cyc;
            if (k == 3) in_valid = 1'b0;
            check($sformatf("b2b%0d_latency", k), 64'(n), 64'(STEPS));
            check($sformatf("b2b%0d_data", k), out_state1, ref_sub64(bs[k]));
            if (k > 0)
                check($sformatf("b2b%0d_spacing", k), 64'(outcyc[k] - outcyc[k - 1]), 64'(STEPS + 2));
        end
        @(posedge CLK);
        @(negedge CLK);

        // Backpressure in DONE, with a competing input offered meanwhile
        out_ready = 1'b0;
        wait_ready("bp_ready");
        in_valid = 1'b1;
        in_state = 64'h0123456789ABCDEF;
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
        wait_out(n);
        check("bp_latency", 64'(n), 64'(STEPS));
        held = out_state1;
        check("bp_data", held, 64'hCAD3EBF789150246);
        in_valid = 1'b1;
        in_state = 64'hFFFFFFFFFFFFFFFF;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            check($sformatf("bp_ov%0d", i), 64'(out_valid1), 64'd1);
            check($sformatf("bp_st%0d", i), out_state1, 64'hCAD3EBF789150246);
            check($sformatf("bp_rdy%0d", i), 64'(in_ready1), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("bp_rel_ov", 64'(out_valid1), 64'd0);
        check("bp_rel_rdy", 64'(in_ready1), 64'd1);
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
        check("bp_new_busy", 64'(busy1), 64'd1);
        wait_out(n);
        check("bp_new_latency", 64'(n), 64'(STEPS));
        check("bp_new_data", out_state1, 64'h6666666666666666);
        @(posedge CLK);
        @(negedge CLK);

        // Reset mid-SUB
        wait_ready("rm_ready");
        in_valid = 1'b1;
        in_state = 64'h0123456789ABCDEF;
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
        repeat (5) @(posedge CLK);
        #1 RST = 1'b1;
        #1;
        check("rm_ov", 64'(out_valid1), 64'd0);
        check("rm_busy", 64'(busy1), 64'd0);
        check("rm_state", out_state1, 64'h0);
        check("rm_rdy", 64'(in_ready1), 64'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 18; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (out_valid1) check($sformatf("rm_spurious%0d", i), 64'(out_valid1), 64'd0);
        end
        check("rm_rel_rdy", 64'(in_ready1), 64'd1);
        run_one("rm_fresh", 64'h0123456789ABCDEF, 64'hCAD3EBF789150246);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
